// File: rtl/clk_rst_seq.sv
// Power-up reset sequencer: PLL reset, filtered lock acceptance, chip reset stretch,
// staggered per-channel reset release and per-channel clock-enable dividers.
module clk_rst_seq #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned PLL_RST_CYC = 4,
    parameter int unsigned LOCK_FILT   = 4,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned STAGGER     = 8,
    parameter int unsigned DIV_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_sw,
    input  logic                    locked,
    input  logic                    lock_clr,
    input  logic [CH_NUM*DIV_W-1:0] div,
    output logic                    pll_reset,
    output logic                    chip_reset,
    output logic [CH_NUM-1:0]       ch_reset,
    output logic [CH_NUM-1:0]       ch_en,
    output logic                    lock_lost,
    output logic [7:0]              lost_cnt
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LOST_W = 8;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STRETCH   = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        sw_sync;
    logic [1:0]        lk_sync;
    logic              reset_sw_s;
    logic              locked_s;
    logic              lock_drop;
    logic [CH_NUM-1:0] rel_now;
    logic [CH_NUM-1:0] ch_hold;
    logic [DIV_W-1:0]  dcnt [CH_NUM];

    // Two-flop synchronisers for the asynchronous switch and lock inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync <= '0;
            lk_sync <= '0;
        end else begin
            sw_sync <= {sw_sync[0], reset_sw};
            lk_sync <= {lk_sync[0], locked};
        end
    end

    assign reset_sw_s = sw_sync[1];
    assign locked_s   = lk_sync[1];

    // Channels released on this edge, and channels that will be held in reset after it.
    always_comb begin
        rel_now   = '0;
        lock_drop = ~reset_sw_s & ~locked_s &
                    ((state == S_STRETCH) || (state == S_RELEASE) || (state == S_RUN));
        for (int k = 0; k < int'(CH_NUM); k++) begin
            rel_now[k] = (state == S_RELEASE) &&
                         (cnt + CNT_W'(1) == CNT_W'(STAGGER * (k + 1)));
        end
        ch_hold = (reset || reset_sw_s || lock_drop) ? '1 : (ch_reset & ~rel_now);
    end

    // Sequencing FSM; cnt is the phase timer, reused as the lock filter in WAIT_LOCK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            chip_reset <= 1'b1;
            ch_reset   <= '1;
            lock_lost  <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            if (lock_clr) begin
                lock_lost <= 1'b0;
            end
            if (reset_sw_s) begin
                state      <= S_PLL_RST;
                cnt        <= '0;
                pll_reset  <= 1'b1;
                chip_reset <= 1'b1;
                ch_reset   <= '1;
            end else if (lock_drop) begin
                state      <= S_WAIT_LOCK;
                cnt        <= '0;
                chip_reset <= 1'b1;
                ch_reset   <= '1;
                lock_lost  <= 1'b1;
                if (lost_cnt != '1) begin
                    lost_cnt <= lost_cnt + LOST_W'(1);
                end
            end else begin
                case (state)
                    S_PLL_RST: begin
                        if (cnt == CNT_W'(PLL_RST_CYC)) begin
                            state     <= S_WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (!locked_s) begin
                            cnt <= '0;
                        end else if (cnt + CNT_W'(1) == CNT_W'(LOCK_FILT)) begin
                            state <= S_STRETCH;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_STRETCH: begin
                        if (cnt + CNT_W'(1) == CNT_W'(STRETCH)) begin
                            state      <= S_RELEASE;
                            cnt        <= '0;
                            chip_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        cnt      <= cnt + CNT_W'(1);
                        ch_reset <= ch_reset & ~rel_now;
                        if (rel_now[CH_NUM-1]) begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        state <= S_RUN;
                    end
                    default: begin
                        state <= S_PLL_RST;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Per-channel dividers, gated by the reset value the channel will have after this edge.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(CH_NUM); k++) begin
            if (ch_hold[k]) begin
                dcnt[k]  <= '0;
                ch_en[k] <= 1'b0;
            end else if (dcnt[k] >= div[k*DIV_W +: DIV_W]) begin
                dcnt[k]  <= '0;
                ch_en[k] <= 1'b1;
            end else begin
                dcnt[k]  <= dcnt[k] + DIV_W'(1);
                ch_en[k] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: phase/elapsed-time model checked every cycle, plus
// hand-computed edge numbers for the default parameter set.
module tb_clk_rst_seq;
    localparam int CH          = 4;
    localparam int DW          = 8;
    localparam int PLL_RST_CYC = 4;
    localparam int LOCK_FILT   = 4;
    localparam int STRETCH     = 16;
    localparam int STAGGER     = 8;
    localparam int DIVS [CH]   = '{0, 3, 255, 1};

    logic            clk = 1'b0;
    logic            reset;
    logic            reset_sw;
    logic            locked;
    logic            lock_clr;
    logic [CH*DW-1:0] div;
    logic            pll_reset;
    logic            chip_reset;
    logic [CH-1:0]   ch_reset;
    logic [CH-1:0]   ch_en;
    logic            lock_lost;
    logic [7:0]      lost_cnt;

    int total = 0;
    int bad   = 0;

    clk_rst_seq #(
        .CH_NUM(CH), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_FILT(LOCK_FILT),
        .STRETCH(STRETCH), .STAGGER(STAGGER), .DIV_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .reset_sw(reset_sw), .locked(locked),
        .lock_clr(lock_clr), .div(div), .pll_reset(pll_reset),
        .chip_reset(chip_reset), .ch_reset(ch_reset), .ch_en(ch_en),
        .lock_lost(lock_lost), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: current phase and cycles elapsed in it.
    typedef enum int {P_PLL, P_WAIT, P_STR, P_REL, P_RUN} ph_e;
    ph_e        ph;
    int         el;
    logic [1:0] msw, mlk;
    int         cyc_last = -1;
    bit         mvalid = 1'b0;
    logic       m_pll, m_chip, m_lost;
    logic [CH-1:0] m_ch, m_en, prev_ch;
    logic [7:0] m_cnt;
    int         anchor [CH];
    logic       sw_s, lk_s, ev;

    always @(posedge clk) begin
        if (reset) begin
            ph = P_PLL; el = 0; msw = '0; mlk = '0;
            m_pll = 1'b1; m_chip = 1'b1; m_ch = '1; m_en = '0;
            m_lost = 1'b0; m_cnt = '0; cyc_last = -1; mvalid = 1'b1;
        end else begin
            sw_s = msw[1];
            lk_s = mlk[1];
            msw  = {msw[0], reset_sw};
            mlk  = {mlk[0], locked};
            cyc_last++;
            ev = 1'b0;
            if (sw_s) begin
                ph = P_PLL; el = 0;
            end else if (!lk_s && (ph == P_STR || ph == P_REL || ph == P_RUN)) begin
                ph = P_WAIT; el = 0; ev = 1'b1;
            end else begin
                case (ph)
                    P_PLL:  begin el++; if (el == PLL_RST_CYC + 1) begin ph = P_WAIT; el = 0; end end
                    P_WAIT: begin el = lk_s ? el + 1 : 0; if (el == LOCK_FILT) begin ph = P_STR; el = 0; end end
                    P_STR:  begin el++; if (el == STRETCH) begin ph = P_REL; el = 0; end end
                    P_REL:  begin el++; if (el == STAGGER * CH) ph = P_RUN; end
                    default: ;
                endcase
            end
            if (ev) m_lost = 1'b1;
            else if (lock_clr) m_lost = 1'b0;
            if (ev && m_cnt != 8'hFF) m_cnt++;
            m_pll  = (ph == P_PLL);
            m_chip = (ph == P_PLL || ph == P_WAIT || ph == P_STR);
            prev_ch = m_ch;
            for (int k = 0; k < CH; k++) begin
                if (ph == P_RUN) m_ch[k] = 1'b0;
                else if (ph == P_REL) m_ch[k] = !(el >= STAGGER * (k + 1));
                else m_ch[k] = 1'b1;
                if (prev_ch[k] && !m_ch[k]) anchor[k] = cyc_last;
                m_en[k] = !m_ch[k] && (((cyc_last - anchor[k]) % (DIVS[k] + 1)) == DIVS[k]);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            total++;
            if ({pll_reset, chip_reset, ch_reset, ch_en, lock_lost, lost_cnt} !==
                {m_pll, m_chip, m_ch, m_en, m_lost, m_cnt}) begin
                bad++;
                $display("FAIL model_cmp cyc=%0d got pll=%b chip=%b ch=%b en=%b lost=%b cnt=%0d exp pll=%b chip=%b ch=%b en=%b lost=%b cnt=%0d",
                         cyc_last, pll_reset, chip_reset, ch_reset, ch_en, lock_lost, lost_cnt,
                         m_pll, m_chip, m_ch, m_en, m_lost, m_cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_last, got, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc_last < n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pll"}, pll_reset, 1);
        chk({tag, "_chip"}, chip_reset, 1);
        chk({tag, "_ch"}, ch_reset, 4'hF);
        chk({tag, "_en"}, ch_en, 0);
        chk({tag, "_lost"}, lock_lost, 0);
        chk({tag, "_cnt"}, lost_cnt, 0);
    endtask

    initial begin
        reset = 1'b1; reset_sw = 1'b0; locked = 1'b1; lock_clr = 1'b0;
        for (int k = 0; k < CH; k++) div[k*DW +: DW] = DW'(DIVS[k]);
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        // Power-up sequence with lock held high.
        wait_edge(3);   chk("pll_e3", pll_reset, 1);
        wait_edge(4);   chk("pll_e4", pll_reset, 0);
        wait_edge(23);  chk("chip_e23", chip_reset, 1);
        wait_edge(24);  chk("chip_e24", chip_reset, 0);
        wait_edge(31);  chk("ch_e31", ch_reset, 4'hF);
        wait_edge(32);  chk("ch_e32", ch_reset, 4'hE); chk("en0_e32", ch_en[0], 1);
        wait_edge(40);  chk("ch_e40", ch_reset, 4'hC);
        wait_edge(42);  chk("en1_e42", ch_en[1], 0);
        wait_edge(43);  chk("en1_e43", ch_en[1], 1);
        wait_edge(47);  chk("en1_e47", ch_en[1], 1);
        wait_edge(48);  chk("ch_e48", ch_reset, 4'h8);
        wait_edge(55);  chk("ch_e55", ch_reset, 4'h8);
        wait_edge(56);  chk("ch_e56", ch_reset, 4'h0);
        wait_edge(57);  chk("en3_e57", ch_en[3], 1);
        wait_edge(58);  chk("en3_e58", ch_en[3], 0);
        wait_edge(302); chk("en2_e302", ch_en[2], 0);
        wait_edge(303); chk("en2_e303", ch_en[2], 1);
        wait_edge(559); chk("en2_e559", ch_en[2], 1);

        // Lock loss in RUN, then recovery without a PLL reset pulse.
        wait_edge(600); locked = 1'b0;
        wait_edge(602); chk("chip_e602", chip_reset, 0);
        wait_edge(603); chk("chip_e603", chip_reset, 1); chk("ch_e603", ch_reset, 4'hF);
                        chk("pll_e603", pll_reset, 0); chk("lost_e603", lock_lost, 1);
                        chk("cnt_e603", lost_cnt, 1);
        wait_edge(610); locked = 1'b1;
        wait_edge(631); chk("chip_e631", chip_reset, 1);
        wait_edge(632); chk("chip_e632", chip_reset, 0);

        // Clear alone, then clear colliding with a second loss.
        wait_edge(650); lock_clr = 1'b1;
        wait_edge(651); lock_clr = 1'b0; chk("lost_clr_e651", lock_lost, 0);
        wait_edge(700); locked = 1'b0;
        wait_edge(702); lock_clr = 1'b1;
        wait_edge(703); lock_clr = 1'b0;
                        chk("lost_e703", lock_lost, 1); chk("cnt_e703", lost_cnt, 2);

        // One-cycle lock glitch while filtering.
        wait_edge(705); locked = 1'b1;
        wait_edge(708); locked = 1'b0;
        wait_edge(709); locked = 1'b1;
        wait_edge(727); chk("chip_e727", chip_reset, 1);
        wait_edge(730); chk("chip_e730", chip_reset, 1);
        wait_edge(731); chk("chip_e731", chip_reset, 0);

        // Switch reset during RELEASE after channel 0 is out of reset.
        wait_edge(740); reset_sw = 1'b1;
        wait_edge(741); reset_sw = 1'b0;
        wait_edge(742); chk("ch_e742", ch_reset, 4'hE); chk("pll_e742", pll_reset, 0);
        wait_edge(743); chk("ch_e743", ch_reset, 4'hF); chk("pll_e743", pll_reset, 1);
                        chk("chip_e743", chip_reset, 1);
        wait_edge(747); chk("pll_e747", pll_reset, 1);
        wait_edge(748); chk("pll_e748", pll_reset, 0);
        wait_edge(768); chk("chip_e768", chip_reset, 0);
        wait_edge(800); chk("ch_e800", ch_reset, 4'h0); chk("cnt_e800", lost_cnt, 2);

        // Repeated lock losses drive the counter into saturation.
        wait_edge(820);
        for (int i = 0; i < 256; i++) begin
            locked = 1'b0;
            repeat (4) @(negedge clk);
            locked = 1'b1;
            repeat (10) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("cnt_sat", lost_cnt, 255);
        chk("lost_sat", lock_lost, 1);

        // Reset in the middle of a sequence restarts cleanly.
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("mid_rst");
        reset = 1'b0;
        wait_edge(3);  chk("re_pll_e3", pll_reset, 1);
        wait_edge(4);  chk("re_pll_e4", pll_reset, 0);
        wait_edge(24); chk("re_chip_e24", chip_reset, 0);
        wait_edge(60); chk("re_ch_e60", ch_reset, 4'h0); chk("re_cnt_e60", lost_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
Parameters:
REQ-001 CH_NUM, 4, number of downstream reset/clock-enable channels (1..8).
REQ-002 PLL_RST_CYC, 4, cycles pll_reset is held after any (re)start.
REQ-003 LOCK_FILT, 4, consecutive synchronised locked=1 cycles required to accept lock.
REQ-004 STRETCH, 16, chip_reset hold cycles after lock is accepted.
REQ-005 STAGGER, 8, cycles between successive channel reset releases.
REQ-006 DIV_W, 8, width of each per-channel divisor.

Ports (name, direction, width, meaning):
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high block reset.
REQ-009 reset_sw  in  1  raw reset switch, active-high, asynchronous to clk.
REQ-010 locked  in  1  raw PLL lock indication, asynchronous to clk.
REQ-011 lock_clr  in  1  single-cycle clear of lock_lost.
REQ-012 div  in  CH_NUM*DIV_W  per-channel divisor; channel k uses bits [k*DIV_W +: DIV_W].
REQ-013 pll_reset  out  1  PLL reset request, active-high.
REQ-014 chip_reset  out  1  global chip reset, active-high.
REQ-015 ch_reset  out  CH_NUM  per-channel reset, active-high.
REQ-016 ch_en  out  CH_NUM  per-channel clock-enable strobe.
REQ-017 lock_lost  out  1  sticky flag: lock dropped after acceptance.
REQ-018 lost_cnt  out  8  saturating count of lock-loss events.

Function
REQ-019 reset_sw and locked SHALL each pass through a 2-flop synchroniser (flops reset to 0), giving reset_sw_s and locked_s. All outputs SHALL be registered.
REQ-020 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STRETCH, RELEASE and RUN.
REQ-021 PLL_RST: pll_reset=1. After PLL_RST_CYC cycles, go to WAIT_LOCK.
REQ-022 WAIT_LOCK: the filter counter SHALL increment on locked_s=1 and clear on locked_s=0. When the count reaches LOCK_FILT, go to STRETCH.
REQ-023 STRETCH: after STRETCH cycles, go to RELEASE. chip_reset SHALL deassert on the same edge.
REQ-024 RELEASE: ch_reset[k] SHALL deassert STAGGER*(k+1) cycles after chip_reset deasserts, channel 0 first. Go to RUN on the edge that releases channel CH_NUM-1.
REQ-025 chip_reset=1 and ch_reset=all-ones SHALL hold in every state before release.
REQ-026 reset_sw_s=1 in any state SHALL force the next state to PLL_RST and re-assert pll_reset, chip_reset and all ch_reset on that edge. This has the highest priority.
REQ-027 locked_s=0 in STRETCH, RELEASE or RUN SHALL force WAIT_LOCK and re-assert chip_reset and all ch_reset; pll_reset stays 0.
REQ-028 Each such event SHALL set lock_lost and increment lost_cnt, saturating at 255.
REQ-029 lock_clr SHALL clear lock_lost. If a lock-loss event occurs in the same cycle, set wins. lost_cnt is cleared only by reset.
REQ-030 Channel k divider: while ch_reset[k]=1, the counter is 0 and ch_en[k]=0.
REQ-031 Otherwise the channel k counter SHALL increment each cycle. When counter >= div_k, ch_en[k]=1 for one cycle and the counter returns to 0 (period div_k+1).
REQ-032 div_k=0 SHALL give ch_en[k] constantly 1. div SHALL be compared live, with no shadow register.
REQ-033 Latency from a reset_sw or locked edge to an output change SHALL be 3 cycles (2 sync + 1 FSM).

Reset
REQ-034 reset=1 SHALL force state=PLL_RST, all counters=0, pll_reset=1, chip_reset=1, ch_reset=all-ones, ch_en=0, lock_lost=0, lost_cnt=0.
REQ-035 Reset mid-sequence SHALL restart the sequence from PLL_RST with no residual counts.

Verification (defaults; cycle 0 = first edge with reset=0)
REQ-036 locked=1 throughout -> pll_reset falls at cycle 4, chip_reset at 24, ch_reset[0..3] at 32/40/48/56, RUN at 56.
REQ-037 RUN with div0=0, div1=3, div2=255 -> ch_en[0] constant 1, ch_en[1] every 4 cycles, ch_en[2] every 256 cycles.
REQ-038 locked glitches low for 1 cycle during WAIT_LOCK -> filter restarts, and STRETCH is entered LOCK_FILT cycles after locked_s returns high.
REQ-039 locked drops in RUN -> all resets re-assert 3 cycles later, lock_lost=1, lost_cnt=1. Lock restored -> sequence resumes from WAIT_LOCK with pll_reset never pulsed. lock_clr in the same cycle as a second drop -> lock_lost=1, lost_cnt=2.
REQ-040 reset_sw pulse in RELEASE after ch_reset[0] is released -> ch_reset[0] and pll_reset re-assert 3 cycles later, and the full sequence repeats.
REQ-041 256 induced lock losses -> lost_cnt saturates at 255.
